// File: rtl/word_unpacker.sv
// Word-to-byte unpacker: pops DW-bit words from a one-word FIFO and emits them
// least-significant byte first on a valid/ready byte stream.
module word_unpacker #(
    parameter int DW = 32,
    parameter int BW = 8
) (
    input  logic          Clk,
    input  logic          ARstN,
    input  logic          FifoEty,
    input  logic [DW-1:0] FifoData,
    output logic          FifoRd,
    output logic [BW-1:0] ByteData,
    output logic          ByteValid,
    input  logic          ByteReady,
    output logic          Busy,
    output logic [15:0]   WordCnt
);

    localparam int NB = DW / BW;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    if ((DW % BW) != 0 || NB < 1) begin : g_param_check
        $error("word_unpacker: DW must be a non-zero multiple of BW");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [DW-1:0] shreg, shreg_nxt;
    logic [15:0]   word_cnt, word_cnt_nxt;
    logic          xfer;
    logic          last;

    assign xfer = (state == SEND) && ByteReady;
    assign last = (idx == LAST_IDX);

    // The pop is gated by ARstN so the FIFO is never drained while held in reset.
    assign FifoRd = ARstN && !FifoEty && ((state == IDLE) || (xfer && last));

    // In IDLE the register is untouched, so the last emitted byte stays visible.
    assign ByteData  = shreg[BW-1:0];
    assign ByteValid = (state == SEND);
    assign Busy      = (state == SEND);
    assign WordCnt   = word_cnt;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt    = state;
        idx_nxt      = idx;
        shreg_nxt    = shreg;
        word_cnt_nxt = word_cnt;

        if (xfer) begin
            if (last) begin
                word_cnt_nxt = word_cnt + 16'd1;
                state_nxt    = IDLE;
            end else begin
                shreg_nxt = shreg >> BW;
                idx_nxt   = idx + 1'b1;
            end
        end

        // A pop overrides the end-of-word return to IDLE: back-to-back words, no bubble.
        if (FifoRd) begin
            shreg_nxt = FifoData;
            idx_nxt   = '0;
            state_nxt = SEND;
        end
    end

    always_ff @(posedge Clk or negedge ARstN) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!ARstN) begin
            state    <= IDLE;
            idx      <= '0;
            shreg    <= '0;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            shreg    <= shreg_nxt;
            word_cnt <= word_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_word_unpacker.sv
// Scoreboard bench for word_unpacker: queued source words feed a FIFO model and
// the expected bytes are compared as the byte stream transfers them.
module tb_word_unpacker;

    logic        Clk = 1'b0;
    logic        ARstN = 1'b0;
    logic        FifoEty = 1'b1;
    logic [31:0] FifoData = 32'h0;
    logic        FifoRd;
    logic [7:0]  ByteData;
    logic        ByteValid;
    logic        ByteReady = 1'b0;
    logic        Busy;
    logic [15:0] WordCnt;

    // Single-byte-word instance used for the 16-bit counter wrap (one word per cycle).
    logic        w_ety = 1'b1;
    logic [7:0]  w_data = 8'h5A;
    logic        w_rd;
    logic [7:0]  w_bdata;
    logic        w_bvalid;
    logic        w_ready = 1'b1;
    logic        w_busy;
    logic [15:0] w_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] src_q[$];
    logic [7:0]  exp_q[$];
    logic        do_pop;
    logic [7:0]  exp_byte;

    always #5 Clk = ~Clk;

    word_unpacker #(.DW(32), .BW(8)) dut (
        .Clk(Clk), .ARstN(ARstN), .FifoEty(FifoEty), .FifoData(FifoData),
        .FifoRd(FifoRd), .ByteData(ByteData), .ByteValid(ByteValid),
        .ByteReady(ByteReady), .Busy(Busy), .WordCnt(WordCnt)
    );

    word_unpacker #(.DW(8), .BW(8)) u_wrap (
        .Clk(Clk), .ARstN(ARstN), .FifoEty(w_ety), .FifoData(w_data),
        .FifoRd(w_rd), .ByteData(w_bdata), .ByteValid(w_bvalid),
        .ByteReady(w_ready), .Busy(w_busy), .WordCnt(w_cnt)
    );

    task automatic push_word(input logic [31:0] w);
        src_q.push_back(w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    // Monitor: samples on the falling edge, applies FIFO pops just after the rising edge.
    always begin
        @(negedge Clk);
        do_pop = 1'b0;
        if (ARstN === 1'b1) begin
            checks++;
            if (ByteValid !== Busy) begin
                errors++;
                $display("FAIL valid_eq_busy: ByteValid=%b Busy=%b", ByteValid, Busy);
            end
            checks++;
            if (FifoRd === 1'b1 && FifoEty === 1'b1) begin
                errors++;
                $display("FAIL no_underflow: FifoRd=1 while FifoEty=1");
            end
            do_pop = (FifoRd === 1'b1);
            if (ByteValid === 1'b1 && ByteReady === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: unexpected byte %h, nothing expected", ByteData);
                end else begin
                    exp_byte = exp_q.pop_front();
                    if (ByteData !== exp_byte) begin
                        errors++;
                        $display("FAIL sb_byte: got %h expected %h", ByteData, exp_byte);
                    end
                end
            end
        end
        @(posedge Clk);
        #1;
        if (do_pop && src_q.size() > 0) void'(src_q.pop_front());
        #1;
        FifoEty  = (src_q.size() == 0);
        FifoData = (src_q.size() > 0) ? src_q[0] : 32'h0;
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk);
            if (ByteValid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        ARstN     = 1'b0;
        ByteReady = 1'b1;
        push_word(32'h44332211);
        repeat (3) @(negedge Clk);
        checks++; if (FifoRd !== 1'b0) begin errors++; $display("FAIL rst_fifo_rd: got %b expected 0", FifoRd); end
        checks++; if (ByteValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", ByteValid); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", Busy); end
        checks++; if (WordCnt !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h expected 0000", WordCnt); end
        checks++; if (ByteData !== 8'h0) begin errors++; $display("FAIL rst_data: got %h expected 00", ByteData); end
        @(posedge Clk);
        #3 ARstN = 1'b1;
        #1;
        checks++; if (FifoRd !== 1'b1) begin errors++; $display("FAIL first_pop: got %b expected 1", FifoRd); end
    endtask

    task automatic test_single;
        int rd_cnt = 0;
        @(negedge Clk);
        rd_cnt += int'(FifoRd);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            rd_cnt += int'(FifoRd);
            checks++;
            if (ByteValid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b expected 1", i, ByteValid); end
        end
        @(negedge Clk);
        rd_cnt += int'(FifoRd);
        checks++; if (ByteValid !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", ByteValid); end
        checks++; if (WordCnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", WordCnt); end
        checks++; if (ByteData !== 8'h44) begin errors++; $display("FAIL idle_hold: got %h expected 44", ByteData); end
        checks++; if (rd_cnt != 1) begin errors++; $display("FAIL single_pops: got %0d expected 1", rd_cnt); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [15:0] base;
        @(posedge Clk);
        #1;
        base = WordCnt;
        push_word(32'hA3A2A1A0);
        push_word(32'hB3B2B1B0);
        wait_valid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got no valid expected valid"); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ByteValid !== 1'b1) begin errors++; $display("FAIL b2b_bubble[%0d]: got %b expected 1", i, ByteValid); end
            checks++;
            if (FifoRd !== (i == 3)) begin errors++; $display("FAIL b2b_rd[%0d]: got %b expected %b", i, FifoRd, (i == 3)); end
            if (i < 7) @(negedge Clk);
        end
        @(negedge Clk);
        checks++; if (ByteValid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", ByteValid); end
        checks++; if (WordCnt !== base + 16'd2) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", WordCnt, base + 16'd2); end
    endtask

    task automatic test_backpressure;
        bit ok;
        logic [15:0] base;
        @(posedge Clk);
        #1;
        base = WordCnt;
        push_word(32'hDDCCBBAA);
        wait_valid(ok);
        checks++; if (!ok || ByteData !== 8'hAA) begin errors++; $display("FAIL bp_first: got %h expected aa", ByteData); end
        @(negedge Clk);
        checks++; if (ByteData !== 8'hBB) begin errors++; $display("FAIL bp_second: got %h expected bb", ByteData); end
        @(posedge Clk);
        #1 ByteReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            checks++; if (ByteValid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, ByteValid); end
            checks++; if (ByteData !== 8'hCC) begin errors++; $display("FAIL bp_hold[%0d]: got %h expected cc", i, ByteData); end
        end
        @(posedge Clk);
        #1 ByteReady = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        checks++; if (ByteData !== 8'hDD || ByteValid !== 1'b1) begin errors++; $display("FAIL bp_after: got %h/%b expected dd/1", ByteData, ByteValid); end
        @(negedge Clk);
        checks++; if (WordCnt !== base + 16'd1) begin errors++; $display("FAIL bp_cnt: got %0d expected %0d", WordCnt, base + 16'd1); end
    endtask

    task automatic test_random;
        logic [15:0] base;
        int cyc = 0;
        @(posedge Clk);
        #1;
        base = WordCnt;
        for (int i = 0; i < 6; i++) push_word($urandom);
        while (exp_q.size() != 0 && cyc < 400) begin
            @(posedge Clk);
            #1 ByteReady = 1'($urandom_range(0, 1));
            cyc++;
        end
        ByteReady = 1'b1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_timeout: got %0d bytes left expected 0", exp_q.size()); end
        @(negedge Clk);
        checks++; if (WordCnt !== base + 16'd6) begin errors++; $display("FAIL rand_cnt: got %0d expected %0d", WordCnt, base + 16'd6); end
        checks++; if (ByteValid !== 1'b0) begin errors++; $display("FAIL rand_idle: got %b expected 0", ByteValid); end
    endtask

    task automatic test_empty;
        logic [15:0] base;
        base = WordCnt;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1 ByteReady = 1'($urandom_range(0, 1));
            @(negedge Clk);
            checks++; if (FifoRd !== 1'b0) begin errors++; $display("FAIL empty_rd[%0d]: got %b expected 0", i, FifoRd); end
            checks++; if (ByteValid !== 1'b0) begin errors++; $display("FAIL empty_valid[%0d]: got %b expected 0", i, ByteValid); end
            checks++; if (WordCnt !== base) begin errors++; $display("FAIL empty_cnt[%0d]: got %0d expected %0d", i, WordCnt, base); end
        end
        ByteReady = 1'b1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        @(posedge Clk);
        #1;
        push_word(32'h87654321);
        wait_valid(ok);
        checks++; if (!ok || ByteData !== 8'h21) begin errors++; $display("FAIL mid_first: got %h expected 21", ByteData); end
        @(posedge Clk);
        #3 ARstN = 1'b0;
        exp_q.delete();
        #1;
        checks++; if (ByteValid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", ByteValid); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", Busy); end
        checks++; if (WordCnt !== 16'h0) begin errors++; $display("FAIL mid_cnt: got %h expected 0000", WordCnt); end
        checks++; if (ByteData !== 8'h0) begin errors++; $display("FAIL mid_data: got %h expected 00", ByteData); end
        checks++; if (FifoRd !== 1'b0) begin errors++; $display("FAIL mid_rd: got %b expected 0", FifoRd); end
        repeat (2) @(negedge Clk);
        @(posedge Clk);
        #3 ARstN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            checks++; if (ByteValid !== 1'b0 || FifoRd !== 1'b0) begin errors++; $display("FAIL mid_after[%0d]: got valid=%b rd=%b expected 0/0", i, ByteValid, FifoRd); end
        end
    endtask

    task automatic test_wrap;
        int n = 0;
        int cyc = 0;
        bit hit = 1'b0;
        @(negedge Clk);
        w_ety = 1'b0;
        while (cyc < 70000) begin
            @(negedge Clk);
            cyc++;
            if (w_bvalid === 1'b1) n++;
            if (w_cnt === 16'hFFFF) begin
                hit = 1'b1;
                break;
            end
        end
        w_ety = 1'b1;
        checks++; if (!hit) begin errors++; $display("FAIL wrap_timeout: got cnt %h expected ffff", w_cnt); end
        checks++; if (n != 65536) begin errors++; $display("FAIL wrap_words: got %0d expected 65536", n); end
        checks++; if (w_bdata !== 8'h5A) begin errors++; $display("FAIL wrap_data: got %h expected 5a", w_bdata); end
        @(negedge Clk);
        checks++; if (w_cnt !== 16'h0) begin errors++; $display("FAIL wrap_cnt: got %h expected 0000", w_cnt); end
        checks++; if (w_bvalid !== 1'b0 || w_busy !== 1'b0) begin errors++; $display("FAIL wrap_idle: got %b/%b expected 0/0", w_bvalid, w_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_empty();
        test_reset_mid();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d bytes expected 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/word_unpacker.md
WORD_UNPACKER -- requirements
Module: word_unpacker

Interface
REQ-001 SHALL have parameter DW, default 32, width of words popped from the upstream one-word FIFO.
REQ-002 SHALL have parameter BW, default 8, width of each emitted byte; DW SHALL be an integer multiple of BW, with NB = DW/BW.
REQ-003 SHALL have port Clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port ARstN, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port FifoEty, input, 1, upstream FIFO empty flag.
REQ-006 SHALL have port FifoData, input, DW, upstream FIFO read data, valid whenever FifoEty=0.
REQ-007 SHALL have port FifoRd, output, 1, pop strobe to the upstream FIFO.
REQ-008 SHALL have port ByteData, output, BW, current output byte.
REQ-009 SHALL have port ByteValid, output, 1, ByteData valid.
REQ-010 SHALL have port ByteReady, input, 1, downstream accept.
REQ-011 SHALL have port Busy, output, 1, high while a word is held (state SEND).
REQ-012 SHALL have port WordCnt, output, 16, count of words fully emitted.

Function
REQ-013 SHALL implement two states: IDLE (no word held) and SEND (word held in shift register, byte index Idx in 0..NB-1).
REQ-014 A byte transfer SHALL occur on a rising edge where ByteValid=1 and ByteReady=1.
REQ-015 FifoRd SHALL be combinational: 1 when (state=IDLE and FifoEty=0), or (state=SEND, Idx=NB-1, byte transfer this cycle, and FifoEty=0); otherwise 0.
REQ-016 FifoRd SHALL never be 1 while FifoEty=1 (no underflow generated).
REQ-017 On any edge with FifoRd=1, FifoData SHALL be loaded into the shift register, Idx set to 0, and state set to SEND.
REQ-018 In SEND: ByteValid=1 and ByteData = shift register bits [BW-1:0], i.e. least significant byte first.
REQ-019 On a byte transfer with Idx<NB-1: shift register SHALL shift right by BW and Idx SHALL increment.
REQ-020 On a byte transfer with Idx=NB-1: WordCnt SHALL increment (wrapping 16'hFFFF -> 0); if FifoRd=1, reload per REQ-017 (back-to-back, no bubble); else state -> IDLE and ByteValid -> 0.
REQ-021 ByteData and ByteValid SHALL be held stable while ByteValid=1 and ByteReady=0 (backpressure, arbitrarily long).
REQ-022 In IDLE: ByteValid=0; ByteData SHALL hold its last value.
REQ-023 Latency: first byte valid the cycle after the FIFO pop; sustained throughput with ByteReady=1 is one byte per cycle, one word per NB cycles.
REQ-024 Busy SHALL equal (state=SEND); ByteValid SHALL equal Busy.
REQ-025 ByteReady while IDLE SHALL have no effect.

Reset
REQ-026 While ARstN=0: state=IDLE, Idx=0, shift register=0, ByteData=0, ByteValid=0, Busy=0, WordCnt=0; FifoRd=0 regardless of FifoEty.
REQ-027 Reset mid-word SHALL discard the held word without emitting its remaining bytes; the word is not re-popped.
REQ-028 After ARstN deasserts, the first pop SHALL occur on the first edge with FifoEty=0.

Verification
REQ-029 Single word: FifoData=32'h44332211, FifoEty=0 for one pop, ByteReady=1 -> FifoRd pulses once; bytes 11,22,33,44 on four consecutive cycles; WordCnt=1; then IDLE.
REQ-030 Back-to-back: words 32'hA3A2A1A0 then 32'hB3B2B1B0 available, ByteReady=1 -> eight consecutive bytes A0..A3,B0..B3 with no bubble; second FifoRd coincides with the A3 transfer.
REQ-031 Backpressure: ByteReady=0 for 5 cycles at Idx=2 of 32'hDDCCBBAA -> ByteData stays 8'hCC, ByteValid=1 throughout; then DD follows.
REQ-032 Empty FIFO: FifoEty=1 for 20 cycles -> FifoRd=0, ByteValid=0, WordCnt unchanged.
REQ-033 Reset mid-word: ARstN low after byte 1 of 32'h87654321 -> all outputs at reset values immediately; after release with FifoEty=1, ByteValid stays 0.
REQ-034 Counter wrap: preload by streaming 65536 words -> WordCnt returns to 0.
